// File: rtl/dm_pkg.sv
// Shared definitions for the single-hart RISC-V debug module: register map,
// abstract-command error codes, register layouts and the abstract FSM states.
package dm_pkg;

    localparam logic [6:0] DM_ADDR_DATA0      = 7'h04;
    localparam logic [6:0] DM_ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] DM_ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] DM_ADDR_HARTINFO   = 7'h12;
    localparam logic [6:0] DM_ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] DM_ADDR_COMMAND    = 7'h17;

    localparam logic [3:0]  DM_VERSION        = 4'd2;
    localparam logic [15:0] DM_REGNO_GPR_BASE = 16'h1000;
    localparam logic [2:0]  DM_AARSIZE_32     = 3'd2;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXCEPTION  = 3'd3,
        CMDERR_HALTRESUME = 3'd4
    } cmderr_e;

    typedef enum logic [1:0] {
        ABS_IDLE = 2'd0,
        ABS_REQ  = 2'd1,
        ABS_WAIT = 2'd2
    } abs_state_e;

    typedef struct packed {
        logic        haltreq;
        logic        resumereq;
        logic [27:0] rsvd;
        logic        ndmreset;
        logic        dmactive;
    } dmcontrol_t;

    typedef struct packed {
        logic [2:0]  rsvd3;
        logic [4:0]  progbufsize;
        logic [10:0] rsvd2;
        logic        busy;
        logic        rsvd1;
        logic [2:0]  cmderr;
        logic [3:0]  rsvd0;
        logic [3:0]  datacount;
    } abstractcs_t;

    typedef struct packed {
        logic [7:0]  cmdtype;
        logic        rsvd0;
        logic [2:0]  aarsize;
        logic        aarpostincrement;
        logic        postexec;
        logic        transfer;
        logic        write;
        logic [15:0] regno;
    } command_t;

    // dmstatus image: every hart-summary pair reports the single hart twice.
    function automatic logic [31:0] dmstatus_value(input logic halted, input logic resumeack);
        logic [31:0] v;
        v        = 32'd0;
        v[3:0]   = DM_VERSION;
        v[7]     = 1'b1;
        v[9:8]   = {halted, halted};
        v[11:10] = {!halted, !halted};
        v[17:16] = {resumeack, resumeack};
        return v;
    endfunction

endpackage

// File: rtl/dm_abstract_fsm.sv
// Abstract command engine: decodes access-register commands, owns cmderr and
// runs the req/ack handshake with the hart GPR port.
module dm_abstract_fsm
    import dm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int GPR_COUNT = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_i,
    input  logic            cmd_wr_i,
    input  logic [7:0]      cmd_cmdtype_i,
    input  logic [2:0]      cmd_aarsize_i,
    input  logic            cmd_postexec_i,
    input  logic            cmd_transfer_i,
    input  logic            cmd_write_i,
    input  logic [15:0]     cmd_regno_i,
    input  logic            abscs_wr_i,
    input  logic [2:0]      abscs_w1c_i,
    input  logic            acc_err_i,
    input  logic [XLEN-1:0] data0_i,
    input  logic            hart_halted_i,
    input  logic            hart_reg_ack_i,
    input  logic [XLEN-1:0] hart_reg_rdata_i,
    output logic            busy_o,
    output logic [2:0]      cmderr_o,
    output logic            rd_update_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            req_o,
    output logic            we_o,
    output logic [4:0]      addr_o,
    output logic [XLEN-1:0] wdata_o
);

    localparam logic [16:0] GPR_BASE = {1'b0, DM_REGNO_GPR_BASE};
    localparam logic [16:0] GPR_END  = 17'(32'h1000 + GPR_COUNT);

    abs_state_e      state_q;
    cmderr_e         cmderr_q;
    logic            req_q;
    logic            we_q;
    logic [4:0]      addr_q;
    logic [XLEN-1:0] wdata_q;

    cmderr_e         dec_err_s;
    logic            dec_go_s;
    logic            busy_s;
    logic [16:0]     regno_ext_s;

    assign busy_s      = (state_q != ABS_IDLE);
    assign regno_ext_s = {1'b0, cmd_regno_i};

    // Command decode: first failing check wins, transfer=0 completes without touching the hart.
    always_comb begin
        dec_err_s = CMDERR_NONE;
        dec_go_s  = 1'b0;
        if ((cmd_cmdtype_i != 8'd0) || cmd_postexec_i ||
            (cmd_transfer_i && (cmd_aarsize_i != DM_AARSIZE_32))) begin
            dec_err_s = CMDERR_NOTSUP;
        end else if (!cmd_transfer_i) begin
            dec_go_s = 1'b0;
        end else if (!hart_halted_i) begin
            dec_err_s = CMDERR_HALTRESUME;
        end else if ((regno_ext_s < GPR_BASE) || (regno_ext_s >= GPR_END)) begin
            dec_err_s = CMDERR_EXCEPTION;
        end else begin
            dec_go_s = 1'b1;
        end
    end

    // Abstract FSM, cmderr and latched GPR request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ABS_IDLE;
            cmderr_q <= CMDERR_NONE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 5'd0;
            wdata_q  <= '0;
        end else if (clear_i) begin
            state_q  <= ABS_IDLE;
            cmderr_q <= CMDERR_NONE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 5'd0;
            wdata_q  <= '0;
        end else begin
            if (busy_s && (cmd_wr_i || abscs_wr_i || acc_err_i)) begin
                if (cmderr_q == CMDERR_NONE) begin
                    cmderr_q <= CMDERR_BUSY;
                end else begin
                    cmderr_q <= cmderr_q;
                end
            end else if (abscs_wr_i) begin
                cmderr_q <= cmderr_e'(cmderr_q & ~abscs_w1c_i);
            end else if (cmd_wr_i && (cmderr_q == CMDERR_NONE)) begin
                if (dec_err_s != CMDERR_NONE) begin
                    cmderr_q <= dec_err_s;
                end else if (dec_go_s) begin
                    state_q <= ABS_REQ;
                    we_q    <= cmd_write_i;
                    addr_q  <= cmd_regno_i[4:0];
                    wdata_q <= data0_i;
                end else begin
                    cmderr_q <= cmderr_q;
                end
            end else begin
                cmderr_q <= cmderr_q;
            end

            case (state_q)
                ABS_IDLE: begin
                    req_q <= 1'b0;
                end
                ABS_REQ: begin
                    req_q   <= 1'b1;
                    state_q <= ABS_WAIT;
                end
                ABS_WAIT: begin
                    if (hart_reg_ack_i) begin
                        req_q   <= 1'b0;
                        state_q <= ABS_IDLE;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ABS_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_s;
    assign cmderr_o    = cmderr_q;
    assign rd_update_o = (state_q == ABS_WAIT) && hart_reg_ack_i && !we_q;
    assign rd_data_o   = hart_reg_rdata_i;
    assign req_o       = req_q;
    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;

endmodule

// File: rtl/dm_core.sv
// Single-hart RISC-V debug module behind the DTM's DMI bus: register decode,
// data0 storage, halt/resume/ndmreset control and the abstract command engine.
module dm_core
    import dm_pkg::*;
#(
    parameter int ABITS     = 7,
    parameter int XLEN      = 32,
    parameter int GPR_COUNT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dmi_start,
    input  logic [1:0]       dmi_op,
    input  logic [ABITS-1:0] dmi_address,
    input  logic [XLEN-1:0]  dmi_wdata,
    output logic [XLEN-1:0]  dmi_rdata,
    output logic             dmi_finish,
    output logic             ndmreset,
    output logic             hart_halt_req,
    output logic             hart_resume_req,
    input  logic             hart_halted,
    output logic             hart_reg_req,
    output logic             hart_reg_we,
    output logic [4:0]       hart_reg_addr,
    output logic [XLEN-1:0]  hart_reg_wdata,
    input  logic [XLEN-1:0]  hart_reg_rdata,
    input  logic             hart_reg_ack
);

    logic            dmactive_q;
    logic            dmactive_d;
    logic            haltreq_q;
    logic            ndmreset_q;
    logic            resume_pending_q;
    logic            resumeack_q;
    logic [XLEN-1:0] data0_q;
    logic [XLEN-1:0] data0_d;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] rdata_d;
    logic            finish_q;

    logic            rd_s;
    logic            wr_s;
    logic            sel_data0_s;
    logic            sel_dmcontrol_s;
    logic            sel_abscs_s;
    logic            sel_command_s;
    logic            busy_s;
    logic [2:0]      cmderr_s;
    logic            rd_update_s;
    logic [XLEN-1:0] rd_data_s;
    logic            acc_err_s;
    dmcontrol_t      dmctl_rd_s;
    abstractcs_t     abscs_rd_s;

    assign rd_s            = dmi_start && (dmi_op == 2'd1);
    assign wr_s            = dmi_start && (dmi_op == 2'd2);
    assign sel_data0_s     = (dmi_address == ABITS'(DM_ADDR_DATA0));
    assign sel_dmcontrol_s = (dmi_address == ABITS'(DM_ADDR_DMCONTROL));
    assign sel_abscs_s     = (dmi_address == ABITS'(DM_ADDR_ABSTRACTCS));
    assign sel_command_s   = (dmi_address == ABITS'(DM_ADDR_COMMAND));
    assign acc_err_s       = (rd_s || wr_s) && sel_data0_s && busy_s;

    // Next dmactive: only a dmcontrol write can change it.
    always_comb begin
        dmactive_d = dmactive_q;
        if (wr_s && sel_dmcontrol_s) begin
            dmactive_d = dmi_wdata[0];
        end else begin
            dmactive_d = dmactive_q;
        end
    end

    // data0 write port: a completing GPR read beats any DMI write (which is blocked while busy anyway).
    always_comb begin
        data0_d = data0_q;
        if (rd_update_s) begin
            data0_d = rd_data_s;
        end else if (wr_s && sel_data0_s && !busy_s && dmactive_q) begin
            data0_d = dmi_wdata;
        end else begin
            data0_d = data0_q;
        end
    end

    // DMI read mux; unmapped addresses and hartinfo read as zero.
    always_comb begin
        dmctl_rd_s           = '0;
        dmctl_rd_s.haltreq   = haltreq_q;
        dmctl_rd_s.ndmreset  = ndmreset_q;
        dmctl_rd_s.dmactive  = dmactive_q;
        abscs_rd_s           = '0;
        abscs_rd_s.busy      = busy_s;
        abscs_rd_s.cmderr    = cmderr_s;
        abscs_rd_s.datacount = 4'd1;
        rdata_d              = '0;
        if (rd_s) begin
            case (dmi_address)
                ABITS'(DM_ADDR_DATA0):      rdata_d = data0_q;
                ABITS'(DM_ADDR_DMCONTROL):  rdata_d = XLEN'(dmctl_rd_s);
                ABITS'(DM_ADDR_DMSTATUS):   rdata_d = XLEN'(dmstatus_value(hart_halted, resumeack_q));
                ABITS'(DM_ADDR_ABSTRACTCS): rdata_d = XLEN'(abscs_rd_s);
                default:                    rdata_d = '0;
            endcase
        end else begin
            rdata_d = '0;
        end
    end

    // DMI response, data0 and run-control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finish_q         <= 1'b0;
            rdata_q          <= '0;
            dmactive_q       <= 1'b0;
            data0_q          <= '0;
            haltreq_q        <= 1'b0;
            ndmreset_q       <= 1'b0;
            resume_pending_q <= 1'b0;
            resumeack_q      <= 1'b0;
        end else begin
            finish_q   <= dmi_start;
            rdata_q    <= dmi_start ? rdata_d : rdata_q;
            dmactive_q <= dmactive_d;
            data0_q    <= dmactive_d ? data0_d : '0;
            if (!dmactive_d) begin
                haltreq_q        <= 1'b0;
                ndmreset_q       <= 1'b0;
                resume_pending_q <= 1'b0;
                resumeack_q      <= 1'b0;
            end else if (wr_s && sel_dmcontrol_s && dmactive_q) begin
                haltreq_q  <= dmi_wdata[31];
                ndmreset_q <= dmi_wdata[1];
                if (dmi_wdata[30] && !dmi_wdata[31]) begin
                    resume_pending_q <= 1'b1;
                    resumeack_q      <= 1'b0;
                end else if (resume_pending_q && !hart_halted) begin
                    resume_pending_q <= 1'b0;
                    resumeack_q      <= 1'b1;
                end else begin
                    resume_pending_q <= resume_pending_q;
                end
            end else if (resume_pending_q && !hart_halted) begin
                resume_pending_q <= 1'b0;
                resumeack_q      <= 1'b1;
            end else begin
                resume_pending_q <= resume_pending_q;
            end
        end
    end

    dm_abstract_fsm #(
        .XLEN      (XLEN),
        .GPR_COUNT (GPR_COUNT)
    ) u_abs (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear_i          (!dmactive_d),
        .cmd_wr_i         (wr_s && sel_command_s),
        .cmd_cmdtype_i    (dmi_wdata[31:24]),
        .cmd_aarsize_i    (dmi_wdata[22:20]),
        .cmd_postexec_i   (dmi_wdata[18]),
        .cmd_transfer_i   (dmi_wdata[17]),
        .cmd_write_i      (dmi_wdata[16]),
        .cmd_regno_i      (dmi_wdata[15:0]),
        .abscs_wr_i       (wr_s && sel_abscs_s),
        .abscs_w1c_i      (dmi_wdata[10:8]),
        .acc_err_i        (acc_err_s),
        .data0_i          (data0_q),
        .hart_halted_i    (hart_halted),
        .hart_reg_ack_i   (hart_reg_ack),
        .hart_reg_rdata_i (hart_reg_rdata),
        .busy_o           (busy_s),
        .cmderr_o         (cmderr_s),
        .rd_update_o      (rd_update_s),
        .rd_data_o        (rd_data_s),
        .req_o            (hart_reg_req),
        .we_o             (hart_reg_we),
        .addr_o           (hart_reg_addr),
        .wdata_o          (hart_reg_wdata)
    );

    assign dmi_rdata       = rdata_q;
    assign dmi_finish      = finish_q;
    assign ndmreset        = ndmreset_q;
    assign hart_halt_req   = haltreq_q;
    assign hart_resume_req = resume_pending_q;

endmodule

// File: tb/tb_dm_core.sv
// Directed bench for dm_core: a vector table of DMI accesses plus hand-written
// sequences for resume, abstract commands, errors, dmactive and async reset.
module tb_dm_core;

    logic        clk;
    logic        rst_n;
    logic        dmi_start;
    logic [1:0]  dmi_op;
    logic [6:0]  dmi_address;
    logic [31:0] dmi_wdata;
    logic [31:0] dmi_rdata;
    logic        dmi_finish;
    logic        ndmreset;
    logic        hart_halt_req;
    logic        hart_resume_req;
    logic        hart_halted;
    logic        hart_reg_req;
    logic        hart_reg_we;
    logic [4:0]  hart_reg_addr;
    logic [31:0] hart_reg_wdata;
    logic [31:0] hart_reg_rdata;
    logic        hart_reg_ack;

    int n_checks = 0;
    int n_fail   = 0;

    dm_core #(.ABITS(7), .XLEN(32), .GPR_COUNT(32)) dut (
        .clk(clk), .rst_n(rst_n), .dmi_start(dmi_start), .dmi_op(dmi_op),
        .dmi_address(dmi_address), .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata),
        .dmi_finish(dmi_finish), .ndmreset(ndmreset), .hart_halt_req(hart_halt_req),
        .hart_resume_req(hart_resume_req), .hart_halted(hart_halted),
        .hart_reg_req(hart_reg_req), .hart_reg_we(hart_reg_we), .hart_reg_addr(hart_reg_addr),
        .hart_reg_wdata(hart_reg_wdata), .hart_reg_rdata(hart_reg_rdata), .hart_reg_ack(hart_reg_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic        halted;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic        halted;
        logic [31:0] cmd;
        logic [31:0] exp_abscs;
        string       name;
    } err_t;

    vec_t vecs[16];
    err_t errs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One DMI transaction: start at a falling edge, return at the next falling edge with finish high.
    task automatic dmi(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd);
        @(negedge clk);
        dmi_start   = 1'b1;
        dmi_op      = op;
        dmi_address = addr;
        dmi_wdata   = wd;
        @(negedge clk);
        dmi_start = 1'b0;
        check("dmi_finish", 32'(dmi_finish), 32'd1);
        rd = dmi_rdata;
    endtask

    task automatic ack(input logic [31:0] rdata);
        @(negedge clk);
        hart_reg_rdata = rdata;
        hart_reg_ack   = 1'b1;
        @(negedge clk);
        hart_reg_ack = 1'b0;
    endtask

    function automatic logic [31:0] ctl_vec();
        return {21'd0, dmi_finish, ndmreset, hart_halt_req, hart_resume_req,
                hart_reg_req, hart_reg_we, hart_reg_addr};
    endfunction

    logic [31:0] rd;
    logic        saw_req;

    initial begin
        vecs[0]  = '{2'd2, 7'h10, 32'h0000_0001, 1'b0, 1'b0, 32'h0,         "dmctl_activate"};
        vecs[1]  = '{2'd1, 7'h11, 32'h0,         1'b0, 1'b1, 32'h0000_0C82, "dmstatus_running"};
        vecs[2]  = '{2'd1, 7'h12, 32'h0,         1'b0, 1'b1, 32'h0,         "hartinfo"};
        vecs[3]  = '{2'd1, 7'h16, 32'h0,         1'b0, 1'b1, 32'h0000_0001, "abstractcs_idle"};
        vecs[4]  = '{2'd1, 7'h20, 32'h0,         1'b0, 1'b1, 32'h0,         "unmapped_rd"};
        vecs[5]  = '{2'd2, 7'h20, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         "unmapped_wr"};
        vecs[6]  = '{2'd1, 7'h20, 32'h0,         1'b0, 1'b1, 32'h0,         "unmapped_rd2"};
        vecs[7]  = '{2'd2, 7'h04, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         "data0_wr"};
        vecs[8]  = '{2'd1, 7'h04, 32'h0,         1'b0, 1'b1, 32'h1234_5678, "data0_rd"};
        vecs[9]  = '{2'd3, 7'h04, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         "op3_noeffect"};
        vecs[10] = '{2'd1, 7'h04, 32'h0,         1'b0, 1'b1, 32'h1234_5678, "data0_after_op3"};
        vecs[11] = '{2'd2, 7'h10, 32'h8000_0001, 1'b0, 1'b0, 32'h0,         "dmctl_haltreq"};
        vecs[12] = '{2'd1, 7'h10, 32'h0,         1'b0, 1'b1, 32'h8000_0001, "dmctl_rd"};
        vecs[13] = '{2'd1, 7'h11, 32'h0,         1'b1, 1'b1, 32'h0000_0382, "dmstatus_halted"};
        vecs[14] = '{2'd2, 7'h10, 32'hC000_0001, 1'b1, 1'b0, 32'h0,         "dmctl_halt_resume"};
        vecs[15] = '{2'd1, 7'h10, 32'h0,         1'b1, 1'b1, 32'h8000_0001, "dmctl_resumereq_rd0"};

        errs[0] = '{1'b1, 32'h0032_1005, 32'h0000_0201, "err_aarsize"};
        errs[1] = '{1'b0, 32'h0022_1005, 32'h0000_0401, "err_running"};
        errs[2] = '{1'b1, 32'h0022_0300, 32'h0000_0301, "err_regno"};
        errs[3] = '{1'b1, 32'h0030_0000, 32'h0000_0001, "notransfer_ok"};

        rst_n = 1'b0; dmi_start = 1'b0; dmi_op = 2'd0; dmi_address = 7'd0; dmi_wdata = 32'd0;
        hart_halted = 1'b0; hart_reg_rdata = 32'd0; hart_reg_ack = 1'b0;
        #12;
        check("reset_ctl", ctl_vec(), 32'd0);
        check("reset_rdata", dmi_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Register-level vectors
        for (int i = 0; i < 16; i++) begin
            hart_halted = vecs[i].halted;
            dmi(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd);
            if (vecs[i].chk) check(vecs[i].name, rd, vecs[i].exp);
        end
        check("halt_req", 32'(hart_halt_req), 32'd1);
        check("resume_ignored", 32'(hart_resume_req), 32'd0);
        @(negedge clk);
        check("finish_width", 32'(dmi_finish), 32'd0);

        // Resume handshake
        dmi(2'd2, 7'h10, 32'h4000_0001, rd);
        check("resume_req_set", 32'(hart_resume_req), 32'd1);
        check("halt_req_clr", 32'(hart_halt_req), 32'd0);
        dmi(2'd1, 7'h11, 32'h0, rd);
        check("dmstatus_pending", rd, 32'h0000_0382);
        hart_halted = 1'b0;
        @(negedge clk);
        check("resume_req_clr", 32'(hart_resume_req), 32'd0);
        dmi(2'd1, 7'h11, 32'h0, rd);
        check("dmstatus_resumeack", rd, 32'h0003_0C82);

        // Abstract GPR read
        hart_halted = 1'b1;
        dmi(2'd2, 7'h10, 32'h8000_0001, rd);
        dmi(2'd2, 7'h17, 32'h0022_1005, rd);
        check("req_not_yet", 32'(hart_reg_req), 32'd0);
        @(negedge clk);
        check("req_rd_ctl", ctl_vec(), {21'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5});
        ack(32'hDEAD_BEEF);
        check("req_drop", 32'(hart_reg_req), 32'd0);
        dmi(2'd1, 7'h04, 32'h0, rd);
        check("data0_gpr", rd, 32'hDEAD_BEEF);
        dmi(2'd1, 7'h16, 32'h0, rd);
        check("abscs_done", rd, 32'h0000_0001);

        // Busy collision: data0 write during WAIT, delayed ack
        dmi(2'd2, 7'h17, 32'h0022_1005, rd);
        @(negedge clk);
        dmi(2'd1, 7'h16, 32'h0, rd);
        check("abscs_busy", rd, 32'h0000_1001);
        dmi(2'd2, 7'h04, 32'h5555_5555, rd);
        repeat (4) @(negedge clk);
        check("req_held", 32'(hart_reg_req), 32'd1);
        ack(32'hCAFE_F00D);
        dmi(2'd1, 7'h16, 32'h0, rd);
        check("abscs_cmderr_busy", rd, 32'h0000_0101);
        dmi(2'd1, 7'h04, 32'h0, rd);
        check("data0_ack_wins", rd, 32'hCAFE_F00D);
        dmi(2'd2, 7'h17, 32'h0023_1003, rd);
        saw_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (hart_reg_req) saw_req = 1'b1;
        end
        check("cmd_ignored_cmderr", 32'(saw_req), 32'd0);
        dmi(2'd2, 7'h16, 32'h0000_0700, rd);
        dmi(2'd1, 7'h16, 32'h0, rd);
        check("abscs_cleared", rd, 32'h0000_0001);

        // Abstract GPR write uses the data0 value at issue
        dmi(2'd2, 7'h17, 32'h0023_1003, rd);
        @(negedge clk);
        check("req_wr_ctl", ctl_vec(), {21'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3});
        check("req_wr_wdata", hart_reg_wdata, 32'hCAFE_F00D);
        ack(32'h0000_0000);
        dmi(2'd1, 7'h04, 32'h0, rd);
        check("data0_kept_on_write", rd, 32'hCAFE_F00D);

        // Decode errors never reach the hart
        for (int e = 0; e < 4; e++) begin
            hart_halted = errs[e].halted;
            dmi(2'd2, 7'h17, errs[e].cmd, rd);
            saw_req = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (hart_reg_req) saw_req = 1'b1;
            end
            check({errs[e].name, "_noreq"}, 32'(saw_req), 32'd0);
            dmi(2'd1, 7'h16, 32'h0, rd);
            check(errs[e].name, rd, errs[e].exp_abscs);
            dmi(2'd2, 7'h16, 32'h0000_0700, rd);
        end

        // Dropping dmactive during WAIT
        hart_halted = 1'b1;
        dmi(2'd2, 7'h17, 32'h0022_1005, rd);
        @(negedge clk);
        check("req_before_deact", 32'(hart_reg_req), 32'd1);
        dmi(2'd2, 7'h10, 32'h0000_0000, rd);
        check("req_deact", 32'(hart_reg_req), 32'd0);
        dmi(2'd1, 7'h16, 32'h0, rd);
        check("abscs_deact", rd, 32'h0000_0001);
        dmi(2'd1, 7'h04, 32'h0, rd);
        check("data0_deact", rd, 32'h0);
        dmi(2'd2, 7'h10, 32'h8000_0001, rd);
        dmi(2'd1, 7'h10, 32'h0, rd);
        check("dmctl_only_active", rd, 32'h0000_0001);

        // Asynchronous reset in the middle of a GPR write
        dmi(2'd2, 7'h10, 32'h8000_0003, rd);
        check("ndmreset_set", 32'(ndmreset), 32'd1);
        dmi(2'd2, 7'h04, 32'h1357_2468, rd);
        dmi(2'd2, 7'h17, 32'h0023_1007, rd);
        @(negedge clk);
        check("req_wdata_pre_rst", hart_reg_wdata, 32'h1357_2468);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ctl", ctl_vec(), 32'd0);
        check("async_rst_wdata", hart_reg_wdata, 32'd0);
        check("async_rst_rdata", dmi_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dmi(2'd2, 7'h10, 32'h0000_0001, rd);
        dmi(2'd1, 7'h11, 32'h0, rd);
        check("dmstatus_after_rst", rd, 32'h0000_0382);
        dmi(2'd1, 7'h04, 32'h0, rd);
        check("data0_after_rst", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
